// File: rtl/riscv_mem_responder_if.sv
// Core-to-memory bus: byte address, lane-replicated store data, store strobe, lane mask, read data.
interface riscv_mem_responder_if;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic        MemWrite;
  logic [3:0]  WMask;
  logic [31:0] ReadData;

  modport master (
    output Address,
    output WriteData,
    output MemWrite,
    output WMask,
    input  ReadData
  );

  modport slave (
    input  Address,
    input  WriteData,
    input  MemWrite,
    input  WMask,
    output ReadData
  );
endinterface

// File: rtl/riscv_mem_responder.sv
// Unified word RAM plus MMIO page (LED, cycle counter, timer compare, status), 1-cycle registered reads.
// Optional: define MEMRESP_BUSERR_EN to trap out-of-range RAM accesses (sticky bus_err, EADR capture).
module riscv_mem_responder #(
  parameter int          MEM_WORDS = 1024,
  parameter logic [19:0] IO_PAGE   = 20'h00010,
  parameter string       INIT_FILE = ""
) (
  input  logic                         clk,
  input  logic                         reset,
  riscv_mem_responder_if.slave         bus,
  output logic [7:0]                   leds,
  output logic                         timer_irq,
  output logic                         bus_err
);
  localparam int AW = $clog2(MEM_WORDS);

  logic [31:0]   r_mem [MEM_WORDS];
  logic [31:0]   r_rdata;
  logic [31:0]   r_cnt;
  logic [31:0]   r_cmp;
  logic [7:0]    r_leds;
  logic          r_match;

  logic          w_io_sel;
  logic          w_oor;
  logic          w_io_wr;
  logic          w_ram_wr;
  logic          w_stat_clr;
  logic [AW-1:0] w_idx;
  logic [9:0]    w_io_off;
  logic [31:0]   w_io_rd;
  logic [31:0]   w_rd;
  logic [31:0]   w_eadr;
  logic          w_unused;

  assign w_io_sel   = (bus.Address[31:12] == IO_PAGE);
  assign w_idx      = bus.Address[AW+1:2];
  assign w_io_off   = bus.Address[11:2];
  assign w_io_wr    = bus.MemWrite & w_io_sel;
  assign w_ram_wr   = bus.MemWrite & ~w_io_sel & ~w_oor;
  assign w_stat_clr = w_io_wr & (w_io_off == 10'd3) & bus.WMask[0] & bus.WriteData[0];
  assign w_unused   = ^bus.Address[1:0];

`ifdef MEMRESP_BUSERR_EN
  localparam logic [29:0] MEM_WORDS_W = 30'(MEM_WORDS);
  logic [31:0] r_eadr;
  logic        r_bus_err;

  // Every RAM-region cycle is an access (fetches and loads included), so decode alone flags it
  assign w_oor = ~w_io_sel & ~(bus.Address[31:2] < MEM_WORDS_W);

  // Sticky error flag and last offending address
  always_ff @(posedge clk) begin
    if (reset) begin
      r_bus_err <= 1'b0;
      r_eadr    <= 32'd0;
    end else if (w_oor) begin
      r_bus_err <= 1'b1;
      r_eadr    <= bus.Address;
    end
  end

  assign w_eadr  = r_eadr;
  assign bus_err = r_bus_err;
`else
  assign w_oor   = 1'b0;
  assign w_eadr  = 32'd0;
  assign bus_err = 1'b0;
`endif

  // MMIO read mux; CNT is the pre-increment value of this cycle
  always_comb begin
    w_io_rd = 32'd0;
    case (w_io_off)
      10'd0:   w_io_rd = {24'd0, r_leds};
      10'd1:   w_io_rd = r_cnt;
      10'd2:   w_io_rd = r_cmp;
      10'd3:   w_io_rd = {31'd0, r_match};
      10'd4:   w_io_rd = w_eadr;
      default: w_io_rd = 32'd0;
    endcase
  end

  // Source select for the registered read port
  always_comb begin
    w_rd = 32'd0;
    if (w_io_sel) begin
      w_rd = w_io_rd;
    end else if (w_oor) begin
      w_rd = 32'd0;
    end else begin
      w_rd = r_mem[w_idx];
    end
  end

  // Read register: old word is returned when the same word is written this cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rdata <= 32'd0;
    end else begin
      r_rdata <= w_rd;
    end
  end

  // RAM byte-lane writes; contents are not reset, but a store in the reset cycle is dropped
  always_ff @(posedge clk) begin
    if (!reset && w_ram_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.WMask[i]) begin
          r_mem[w_idx][8*i +: 8] <= bus.WriteData[8*i +: 8];
        end
      end
    end
  end

  // MMIO registers; a MATCH set in the same cycle as a W1C clear wins
  always_ff @(posedge clk) begin
    if (reset) begin
      r_leds  <= 8'd0;
      r_cnt   <= 32'd0;
      r_cmp   <= 32'hFFFF_FFFF;
      r_match <= 1'b0;
    end else begin
      r_cnt <= r_cnt + 32'd1;
      if (w_io_wr && (w_io_off == 10'd0) && bus.WMask[0]) begin
        r_leds <= bus.WriteData[7:0];
      end
      if (w_io_wr && (w_io_off == 10'd2) && (bus.WMask == 4'hF)) begin
        r_cmp <= bus.WriteData;
      end
      if (r_cnt == r_cmp) begin
        r_match <= 1'b1;
      end else if (w_stat_clr) begin
        r_match <= 1'b0;
      end
    end
  end

  assign bus.ReadData = r_rdata;
  assign leds         = r_leds;
  assign timer_irq    = r_match;
endmodule

// File: tb/tb_riscv_mem_responder.sv
// Scoreboard bench: the driver pushes model expectations per cycle, a monitor compares after each edge.
module tb_riscv_mem_responder;
  localparam int          MW   = 64;
  localparam logic [31:0] IOB  = 32'h0001_0000;

  typedef struct packed {
    logic [31:0] rd;
    logic [7:0]  leds;
    logic        irq;
    logic        berr;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] leds;
  logic       timer_irq;
  logic       bus_err;

  riscv_mem_responder_if bus_if ();

  riscv_mem_responder #(
    .MEM_WORDS (MW),
    .IO_PAGE   (20'h00010),
    .INIT_FILE ("")
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus_if.slave),
    .leds      (leds),
    .timer_irq (timer_irq),
    .bus_err   (bus_err)
  );

  always #5 clk = ~clk;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          n_tests = 0;
  int          n_fail  = 0;

  logic [31:0] m_mem [MW];
  logic [31:0] m_cnt, m_cmp, m_eadr;
  logic [7:0]  m_leds;
  logic        m_match, m_berr;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, want, $time);
    end
  endtask

  // One bus cycle: drive at the falling edge, advance the reference model, queue what must follow
  task automatic cyc(input logic [31:0] a, input logic [31:0] wd, input logic we,
                     input logic [3:0] m, input logic rst, input bit bd);
    exp_t        e;
    logic        io, oor, clr;
    int unsigned w;
    @(negedge clk);
    if (bd) begin
      force dut.r_cnt = 32'hFFFF_FFFE;
      #1;
      release dut.r_cnt;
      m_cnt = 32'hFFFF_FFFE;
    end
    reset = rst;
    bus_if.Address   = a;
    bus_if.WriteData = wd;
    bus_if.MemWrite  = we;
    bus_if.WMask     = m;
    e = '0;
    if (rst) begin
      m_cnt = 32'd0; m_cmp = 32'hFFFF_FFFF; m_match = 1'b0;
      m_leds = 8'd0; m_berr = 1'b0; m_eadr = 32'd0;
      e.rd = 32'd0;
    end else begin
      io = (a[31:12] == 20'h00010);
      w  = a[31:2];
`ifdef MEMRESP_BUSERR_EN
      oor = !io && (w >= MW);
`else
      oor = 1'b0;
`endif
      if (io) begin
        case (a[11:0])
          12'h000: e.rd = {24'd0, m_leds};
          12'h004: e.rd = m_cnt;
          12'h008: e.rd = m_cmp;
          12'h00C: e.rd = {31'd0, m_match};
          12'h010: e.rd = m_eadr;
          default: e.rd = 32'd0;
        endcase
      end else if (oor) begin
        e.rd = 32'd0;
      end else begin
        e.rd = m_mem[w % MW];
      end
      clr = we && io && (a[11:0] == 12'h00C) && m[0] && wd[0];
      if (m_cnt == m_cmp) m_match = 1'b1;
      else if (clr)       m_match = 1'b0;
      if (we && io && a[11:0] == 12'h000 && m[0]) m_leds = wd[7:0];
      if (we && io && a[11:0] == 12'h008 && m == 4'hF) m_cmp = wd;
      if (we && !io && !oor) begin
        for (int i = 0; i < 4; i++) begin
          if (m[i]) m_mem[w % MW][8*i +: 8] = wd[8*i +: 8];
        end
      end
      if (oor) begin
        m_berr = 1'b1;
        m_eadr = a;
      end
      m_cnt = m_cnt + 32'd1;
    end
    e.leds = m_leds;
    e.irq  = m_match;
    e.berr = m_berr;
    exp_q.push_back(e);
  endtask

  task automatic rd(input logic [31:0] a);
    cyc(a, 32'd0, 1'b0, 4'h0, 1'b0, 1'b0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] m);
    cyc(a, wd, 1'b1, m, 1'b0, 1'b0);
  endtask

  // Monitor: compare each registered response shortly after the edge that produced it
  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      if (!$isunknown(mon_e.rd)) check("ReadData", bus_if.ReadData, mon_e.rd);
      check("leds", {24'd0, leds}, {24'd0, mon_e.leds});
      check("timer_irq", {31'd0, timer_irq}, {31'd0, mon_e.irq});
      check("bus_err", {31'd0, bus_err}, {31'd0, mon_e.berr});
    end
  end

  initial begin
    logic [31:0] a;
    int          sel;
    for (int i = 0; i < MW; i++) m_mem[i] = 'x;
    reset = 1'b1;
    bus_if.Address = 32'd0; bus_if.WriteData = 32'd0;
    bus_if.MemWrite = 1'b0; bus_if.WMask = 4'h0;

    cyc(32'd0, 32'd0, 1'b0, 4'h0, 1'b1, 1'b0);
    cyc(32'd0, 32'd0, 1'b0, 4'h0, 1'b1, 1'b0);
    for (int i = 0; i < MW; i++) wr(32'(i) << 2, $urandom, 4'hF);

    // Word 0 holds the first instruction; one-cycle read latency
    wr(32'h0, 32'h0050_0093, 4'hF);
    rd(32'h0);
    rd(32'h4);

    // Single-lane store with same-cycle read of the old word
    wr(32'h10, 32'h1122_3344, 4'hF);
    wr(32'h10, 32'hAAAA_AAAA, 4'b0100);
    rd(32'h10);

    // Timer compare: CMP=10 written at CNT=3, W1C in the match cycle loses, next W1C clears
    cyc(32'd0, 32'd0, 1'b0, 4'h0, 1'b1, 1'b0);
    rd(IOB + 32'h4); rd(IOB + 32'h4); rd(IOB + 32'h4);
    wr(IOB + 32'h8, 32'd10, 4'hF);
    for (int i = 0; i < 6; i++) rd(IOB + 32'hC);
    wr(IOB + 32'hC, 32'h1, 4'h1);
    wr(IOB + 32'hC, 32'h1, 4'h1);
    rd(IOB + 32'hC);
    rd(IOB + 32'h8);

    // Counter wrap through the backdoor
    cyc(IOB + 32'h4, 32'd0, 1'b0, 4'h0, 1'b0, 1'b1);
    rd(IOB + 32'h4); rd(IOB + 32'h4); rd(IOB + 32'h4);

    // LED latch, read-only counter, store dropped by reset
    wr(IOB, 32'h0000_01A5, 4'h1);
    wr(IOB + 32'h4, 32'h0, 4'hF);
    rd(IOB + 32'h4);
    wr(32'h14, 32'hDEAD_BEEF, 4'hF);
    cyc(32'h14, 32'h0BAD_F00D, 1'b1, 4'hF, 1'b1, 1'b0);
    rd(32'h14);
    rd(IOB);

    // Store past the end of RAM: traps when enabled, aliases to word 2 otherwise
    rd(32'h8);
    wr(32'(MW + 2) << 2, 32'h5A5A_1234, 4'hF);
    rd(32'h8);
    rd(IOB + 32'h10);

    // Randomized mix of RAM, out-of-range, MMIO, masks and occasional resets
    for (int n = 0; n < 500; n++) begin
      sel = $urandom_range(0, 9);
      if (sel <= 5)      a = 32'($urandom_range(0, MW - 1)) << 2;
      else if (sel == 6) a = 32'($urandom_range(MW, 4 * MW - 1)) << 2;
      else               a = IOB + (32'($urandom_range(0, 5)) << 2);
      cyc(a, $urandom, 1'($urandom_range(0, 1)),
          ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom_range(0, 15)),
          ($urandom_range(0, 79) == 0), 1'b0);
    end

    for (int i = 0; i < MW; i++) rd(32'(i) << 2);
    rd(32'h0);
    repeat (3) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
